// File: rtl/crc_framer_if.sv
// Byte-stream handshake bundle for crc_framer: payload input side (s_*)
// and framed output side (m_*), each with valid/ready.
interface crc_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    // Upstream/downstream environment view: drives payload, consumes output
    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

    // Framer view: consumes payload, drives framed output
    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/crc_framer.sv
// Transmit framing stage: forwards payload bytes unchanged, then appends the
// frame CRC (MSB byte first, MSB-first non-reflected, no final XOR).
// One output register stage, one byte per cycle, counts completed frames.
module crc_framer #(
    parameter int unsigned    N        = 16,
    parameter logic [N-1:0]   CRC_POLY = 'h8005,
    parameter logic [N-1:0]   CRC_INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    crc_framer_if.slave  bus,
    output logic [15:0]  frame_cnt
);

    localparam int unsigned NB     = N / 8;
    localparam logic [1:0]  K_LAST = 2'(NB - 1);

    localparam logic [0:0] ST_PAYLOAD = 1'b0;
    localparam logic [0:0] ST_APPEND  = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] crc;
    logic [1:0]   k;
    logic         slot_free;
    logic         accept;
    logic [N-1:0] crc_next;
    logic [7:0]   crc_sel;

    // Fold one byte into the CRC, bit 7 first
    function automatic logic [N-1:0] crc_byte(input logic [N-1:0] c_in,
                                              input logic [7:0]   d);
        logic [N-1:0] c;
        logic         fb;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[N-1] ^ d[3'(7 - i)];
            c  = c << 1;
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

    // Handshake qualifiers; s_ready is held low while reset is asserted
    always_comb begin
        slot_free   = !bus.m_valid || bus.m_ready;
        bus.s_ready = rst && (state == ST_PAYLOAD) && slot_free;
        accept      = bus.s_valid && bus.s_ready;
        crc_next    = crc_byte(crc, bus.s_data);
    end

    // Select CRC byte k for the append phase
    always_comb begin
        crc_sel = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (k == 2'(i)) crc_sel = crc[8*i +: 8];
        end
    end

    // Framing FSM, output register stage and CRC accumulator
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_PAYLOAD;
            crc         <= CRC_INIT;
            k           <= '0;
            bus.m_data  <= '0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
        end else begin
            case (state)
                ST_PAYLOAD: begin
                    if (accept) begin
                        bus.m_data  <= bus.s_data;
                        bus.m_valid <= 1'b1;
                        bus.m_last  <= 1'b0;
                        crc         <= crc_next;
                        if (bus.s_last) begin
                            state <= ST_APPEND;
                            k     <= K_LAST;
                        end
                    end else if (slot_free) begin
                        bus.m_valid <= 1'b0;
                    end
                end
                default: begin
                    if (slot_free) begin
                        bus.m_data  <= crc_sel;
                        bus.m_valid <= 1'b1;
                        bus.m_last  <= (k == 2'd0);
                        if (k == 2'd0) begin
                            state <= ST_PAYLOAD;
                            crc   <= CRC_INIT;
                        end else begin
                            k <= k - 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Completed-frame counter, advances on the downstream m_last handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (bus.m_valid && bus.m_ready && bus.m_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_crc_framer.sv
// Self-checking bench for crc_framer: randomized handshakes against a
// polynomial-division CRC reference and an output scoreboard.
module tb_crc_framer;

    localparam int unsigned  N    = 16;
    localparam int unsigned  NB   = N / 8;
    localparam logic [N-1:0] POLY = 16'h8005;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] frame_cnt;

    crc_framer_if bus();

    crc_framer #(
        .N        (N),
        .CRC_POLY (POLY),
        .CRC_INIT (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [8:0]  exp_q[$];   // {last, data} expected on output
    logic [8:0]  obs_q[$];   // {last, data} observed on output
    logic [7:0]  msg_q[$];   // payload of the frame being accepted
    logic [7:0]  tx_q[$];    // payload to send
    logic [15:0] exp_cnt;
    bit          rand_rdy;
    bit          held;
    logic [7:0]  held_data;
    logic        held_last;
    bit          accepted;
    bit          last_sready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Remainder of M(x)*x^N divided by the generator (zero initial value)
    function automatic logic [N-1:0] ref_crc(input logic [7:0] msg[$]);
        logic [N:0] r;
        logic       b;
        r = '0;
        for (int unsigned i = 0; i < msg.size() * 8 + N; i++) begin
            if (i < msg.size() * 8) b = msg[i / 8][7 - (i % 8)];
            else                    b = 1'b0;
            r = {r[N-1:0], b};
            if (r[N]) r = r ^ {1'b1, POLY};
        end
        return r[N-1:0];
    endfunction

    // One clock cycle: entered and left at a falling edge
    task automatic step();
        logic [N-1:0] c;
        bus.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #2;
        if (held) begin
            check("hold_valid", 32'(bus.m_valid), 32'd1);
            check("hold_data",  32'(bus.m_data),  32'(held_data));
            check("hold_last",  32'(bus.m_last),  32'(held_last));
        end
        if (bus.m_valid && !bus.m_ready)
            check("stall_sready", 32'(bus.s_ready), 32'd0);
        if (bus.m_valid && bus.m_ready) begin
            obs_q.push_back({bus.m_last, bus.m_data});
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(bus.m_valid), 32'd0);
            end else begin
                check("out_byte", 32'({bus.m_last, bus.m_data}), 32'(exp_q[0]));
                if (exp_q[0][8]) exp_cnt = exp_cnt + 16'd1;
                void'(exp_q.pop_front());
            end
        end
        held      = bus.m_valid && !bus.m_ready;
        held_data = bus.m_data;
        held_last = bus.m_last;
        accepted  = bus.s_valid && bus.s_ready;
        last_sready = bus.s_ready;
        if (accepted) begin
            exp_q.push_back({1'b0, bus.s_data});
            msg_q.push_back(bus.s_data);
            if (bus.s_last) begin
                c = ref_crc(msg_q);
                for (int unsigned j = 0; j < NB; j++)
                    exp_q.push_back({j == NB - 1, c[8*(NB-1-j) +: 8]});
                msg_q.delete();
            end
        end
        @(negedge clk);
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    task automatic do_reset(input int unsigned cycles);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        rst = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_m_valid",   32'(bus.m_valid), 32'd0);
        check("rst_m_data",    32'(bus.m_data),  32'd0);
        check("rst_m_last",    32'(bus.m_last),  32'd0);
        check("rst_frame_cnt", 32'(frame_cnt),   32'd0);
        check("rst_s_ready",   32'(bus.s_ready), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        msg_q.delete();
        exp_cnt = '0;
        held = 1'b0;
    endtask

    task automatic send_frame(input bit with_last, input bit gaps);
        for (int unsigned i = 0; i < tx_q.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    bus.s_valid = 1'b0;
                    step();
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = tx_q[i];
            bus.s_last  = with_last && (i == tx_q.size() - 1);
            accepted = 1'b0;
            for (int unsigned t = 0; t < 100 && !accepted; t++) step();
            if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic drain();
        bus.s_valid = 1'b0;
        for (int unsigned t = 0; t < 200 && exp_q.size() != 0; t++) step();
        check("drain", exp_q.size(), 32'd0);
    endtask

    task automatic load_digits();
        tx_q.delete();
        for (int unsigned i = 0; i < 9; i++) tx_q.push_back(8'(8'h31 + i));
    endtask

    initial begin
        int unsigned cnt;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        rand_rdy    = 1'b0;
        exp_cnt     = '0;
        held        = 1'b0;

        do_reset(2);
        step();
        check("sready_after_rst", 32'(last_sready), 32'd1);

        // Single zero byte: 00 00 00, last on the third
        obs_q.delete();
        tx_q = '{8'h00};
        send_frame(1'b1, 1'b0);
        drain();
        check("zero_len", obs_q.size(), 32'd3);
        if (obs_q.size() == 3) begin
            check("zero_b0", 32'(obs_q[0]), 32'h000);
            check("zero_b1", 32'(obs_q[1]), 32'h000);
            check("zero_b2", 32'(obs_q[2]), 32'h100);
        end
        check("zero_cnt", 32'(frame_cnt), 32'd1);

        // Check string with full throughput; input stall length
        obs_q.delete();
        load_digits();
        send_frame(1'b1, 1'b0);
        cnt = 0;
        for (int unsigned t = 0; t < 10; t++) begin
            step();
            if (last_sready) break;
            cnt++;
        end
        check("stall_cycles", cnt, NB);
        drain();
        check("digits_len", obs_q.size(), 32'd11);
        if (obs_q.size() == 11) begin
            check("digits_crc_hi", 32'(obs_q[9]),  32'h0FE);
            check("digits_crc_lo", 32'(obs_q[10]), 32'h1E8);
        end

        // Same frame under random backpressure
        rand_rdy = 1'b1;
        load_digits();
        send_frame(1'b1, 1'b0);
        drain();

        // Back-to-back frames: second CRC must restart from init
        rand_rdy = 1'b0;
        obs_q.delete();
        load_digits();
        send_frame(1'b1, 1'b0);
        tx_q = '{8'h00};
        send_frame(1'b1, 1'b0);
        drain();
        check("b2b_len", obs_q.size(), 32'd14);
        if (obs_q.size() == 14) begin
            check("b2b_crc1_lo", 32'(obs_q[10]), 32'h1E8);
            check("b2b_crc2_hi", 32'(obs_q[12]), 32'h000);
            check("b2b_crc2_lo", 32'(obs_q[13]), 32'h100);
        end

        // Reset after four payload bytes, then a clean frame
        load_digits();
        tx_q = tx_q[0:3];
        send_frame(1'b0, 1'b0);
        do_reset(1);
        obs_q.delete();
        load_digits();
        send_frame(1'b1, 1'b0);
        drain();
        check("post_rst_len", obs_q.size(), 32'd11);
        if (obs_q.size() == 11) begin
            check("post_rst_crc_hi", 32'(obs_q[9]),  32'h0FE);
            check("post_rst_crc_lo", 32'(obs_q[10]), 32'h1E8);
        end

        // Random frames, random gaps and backpressure
        rand_rdy = 1'b1;
        for (int unsigned f = 0; f < 25; f++) begin
            tx_q.delete();
            for (int unsigned i = 0; i < $urandom_range(1, 8); i++)
                tx_q.push_back(8'($urandom));
            send_frame(1'b1, 1'b1);
        end
        drain();

        // Counter wrap: preset near the top, then complete frames
        rand_rdy = 1'b0;
        force dut.frame_cnt = 16'hFFFD;
        #1;
        release dut.frame_cnt;
        exp_cnt = 16'hFFFD;
        for (int unsigned f = 0; f < 3; f++) begin
            tx_q = '{8'($urandom)};
            send_frame(1'b1, 1'b0);
            drain();
        end
        check("frame_cnt_wrap", 32'(frame_cnt), 32'h0000);
        tx_q = '{8'h5A};
        send_frame(1'b1, 1'b0);
        drain();
        check("frame_cnt_after_wrap", 32'(frame_cnt), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
